// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that shares one 4:1 word MUX among four requesters.
// The owner keeps the grant while it holds its request. A hold limit
// (MAX_HOLD) hands the MUX to the next waiting requester, so nobody starves.
// gnt and sel are registered and drive the MUX select directly.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  localparam int CNT_W = $clog2(MAX_HOLD + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Last cycle an owner may keep the MUX while someone else is waiting.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

  logic [0:0]       state_reg, state_next;
  logic [3:0]       gnt_reg, gnt_next;
  logic [1:0]       sel_reg, sel_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;

  // Arbitration helpers
  logic [3:0] owner_oh;    // decoded current owner (valid only in GRANT)
  logic [3:0] others;      // requests from everyone except the owner
  logic [1:0] ptr_rel;     // priority pointer that takes effect on release
  logic [3:0] rot_idle;    // req rotated so bit 0 is the ptr_reg position
  logic [3:0] rot_rel;     // others rotated so bit 0 is the ptr_rel position
  logic [1:0] win_idle;    // winner when arbitrating from IDLE
  logic [1:0] win_rel;     // successor when the owner releases
  logic       owner_req;
  logic       limit_hit;
  logic       release_now;

  // Offset of the lowest set bit of a rotated request vector.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] off;
    off = 2'd3;
    if (v[0])      off = 2'd0;
    else if (v[1]) off = 2'd1;
    else if (v[2]) off = 2'd2;
    return off;
  endfunction

  // One-hot decode of a 2-bit requester index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'(4'b0001 << idx);
  endfunction

  assign ptr_rel = sel_reg + 2'd1;

  // Owner decode and priority rotation, one lane per requester.
  // rot_*[k] holds the request that is k positions after its pointer.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign owner_oh[gi] = (sel_reg == 2'(gi));
      assign rot_idle[gi] = req[ptr_reg + 2'(gi)];
      assign rot_rel[gi]  = others[ptr_rel + 2'(gi)];
    end
  endgenerate

  assign others   = req & ~owner_oh;
  assign win_idle = ptr_reg + first_set(rot_idle);
  // The owner sits last in the rotation from ptr_rel and is masked out of
  // others, so it can never win its own release.
  assign win_rel  = ptr_rel + first_set(rot_rel);

  assign owner_req   = |(req & owner_oh);
  assign limit_hit   = (hold_cnt_reg == HOLD_LAST);
  // Release is decided on this cycle's requests: owner let go, or the hold
  // limit is reached while someone else is waiting.
  assign release_now = !owner_req || (limit_hit && (|others));

  // Next-state logic for the IDLE/GRANT machine, pointer and hold counter.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    sel_next      = sel_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;

    case (state_reg)
      IDLE: begin
        // sel deliberately keeps its last value while idle.
        if (|req) begin
          state_next    = GRANT;
          gnt_next      = onehot(win_idle);
          sel_next      = win_idle;
          hold_cnt_next = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          ptr_next      = ptr_rel;
          hold_cnt_next = '0;
          if (|others) begin
            // Direct hand-over: one-hot to one-hot with no idle bubble.
            gnt_next = onehot(win_rel);
            sel_next = win_rel;
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
          end
        end else if (limit_hit) begin
          // Limit reached but nobody is waiting: keep the grant and start a
          // fresh hold window.
          hold_cnt_next = '0;
        end else if (hold_cnt_reg < HOLD_SAT) begin
          hold_cnt_next = hold_cnt_reg + CNT_W'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        gnt_next      = '0;
        hold_cnt_next = '0;
      end
    endcase
  end

  // State registers. Reset drops any in-flight grant on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      sel_reg      <= sel_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = |gnt_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Directed checks of the round-robin MUX arbiter with hand-computed values.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int total;
  int bad;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic eb);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    logic [3:0] exp_g;
    int         own;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b1111;

    // 1. reset held two cycles with all requests up
    step();
    chk_out("rst_c1", 4'b0000, 2'd0, 1'b0);
    step();
    chk_out("rst_c2", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;

    // 3. all requesting: owners 0,1,2,3,0, eight cycles each, no gap
    for (int k = 0; k < 40; k++) begin
      step();
      own   = (k / 8) % 4;
      exp_g = 4'(4'b0001 << own);
      chk_out($sformatf("rr_k%0d", k), exp_g, 2'(own), 1'b1);
    end

    // owner 0 lets go, nobody else -> idle, ptr becomes 1
    req = 4'b0000;
    step();
    chk_out("to_idle", 4'b0000, 2'd0, 1'b0);

    // 2. requester 2 alone for three cycles, then drops
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_out($sformatf("r2_c%0d", k), 4'b0100, 2'd2, 1'b1);
    end
    req = 4'b0000;
    step();
    chk_out("r2_done", 4'b0000, 2'd2, 1'b0);

    // 4. requester 3 alone for 20 cycles: no drop at the hold boundary
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("solo3_c%0d.gnt", k), 32'(gnt), 32'h8);
    end
    chk("solo3.sel", 32'(sel), 32'd3);
    req = 4'b0000;
    step();
    chk_out("solo3_done", 4'b0000, 2'd3, 1'b0);

    // 5. owner 1 drops while 0 and 2 are waiting -> 2 wins (ptr=2)
    req = 4'b0010;
    step();
    chk_out("own1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0111;
    step();
    chk_out("own1_keep", 4'b0010, 2'd1, 1'b1);
    req = 4'b0101;
    step();
    chk_out("own1_drop", 4'b0100, 2'd2, 1'b1);

    // 6. owner 2 reaches hold_cnt=5, then a one-cycle reset
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("own2_c%0d.gnt", k), 32'(gnt), 32'h4);
    end
    rst = 1'b1;
    step();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    req = 4'b0110;
    step();
    chk_out("post_rst", 4'b0010, 2'd1, 1'b1);

    // requester 1 re-asserts after releasing: it now has lowest priority
    req = 4'b0100;
    step();
    chk_out("hand_2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0011;
    step();
    chk_out("after_2", 4'b0001, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
